// File: rtl/seq_div20.sv
// seq_div20: unsigned restoring divider, one quotient bit per clock.
// Start/busy/done handshake; results held until the next completion.
module seq_div20 #(
   parameter int WIDTH = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] q, q_nxt;
   logic [WIDTH-1:0] d, d_nxt;
   logic [WIDTH-1:0] r, r_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [WIDTH-1:0] quo_nxt, rem_nxt;
   logic             dbz_nxt;
   logic [WIDTH:0]   rs, t;
   logic             last;

   // Partial remainder is always < D between steps, so its top bit
   // lives only in the shifted trial value rs, never in r itself.
   assign rs   = {r, q[WIDTH-1]};
   assign t    = rs - {1'b0, d};
   assign last = (cnt == CW'(WIDTH - 1));

   assign busy = (state == RUN);
   assign done = (state == FIN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         q           <= '0;
         d           <= '0;
         r           <= '0;
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         state       <= state_nxt;
         q           <= q_nxt;
         d           <= d_nxt;
         r           <= r_nxt;
         cnt         <= cnt_nxt;
         quotient    <= quo_nxt;
         remainder   <= rem_nxt;
         div_by_zero <= dbz_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      q_nxt     = q;
      d_nxt     = d;
      r_nxt     = r;
      cnt_nxt   = cnt;
      quo_nxt   = quotient;
      rem_nxt   = remainder;
      dbz_nxt   = div_by_zero;
      unique case (state)
         IDLE, FIN: begin
            state_nxt = IDLE;
            if (start) begin
               if (divisor == '0) begin
                  state_nxt = FIN;
                  quo_nxt   = '1;
                  rem_nxt   = dividend;
                  dbz_nxt   = 1'b1;
               end else begin
                  state_nxt = RUN;
                  q_nxt     = dividend;
                  r_nxt     = '0;
                  d_nxt     = divisor;
                  cnt_nxt   = '0;
               end
            end
         end
         RUN: begin
            if (!t[WIDTH]) begin
               r_nxt = t[WIDTH-1:0];
               q_nxt = {q[WIDTH-2:0], 1'b1};
            end else begin
               r_nxt = rs[WIDTH-1:0];
               q_nxt = {q[WIDTH-2:0], 1'b0};
            end
            cnt_nxt = cnt + CW'(1);
            if (last) begin
               state_nxt = FIN;
               quo_nxt   = q_nxt;
               rem_nxt   = r_nxt;
               dbz_nxt   = 1'b0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
